alu_sequencer: RTL and testbench

ALU_SEQUENCER -- requirements
Module: alu_sequencer

---
 rtl/alu_sequencer.sv | 183 ++++++++++++++++++
 tb/tb_alu_sequencer.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_sequencer.sv
// Multi-cycle control sequencer: fetch, decode and three-bus ALU execute for one instruction at a time.
// Optional build macro MULDIV_EN enables the two-result MUL/DIV ops (opcodes 01111, 10000).
module alu_sequencer (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        run,
  input  logic        mem_ready,
  input  logic [31:0] IR_Data,
  output logic        PC_select,
  output logic        PC_enable,
  output logic        PC_increment_enable,
  output logic        IR_enable,
  output logic        Y_enable,
  output logic        Z_enable,
  output logic        Z_LO_select,
  output logic        Z_HI_select,
  output logic        MAR_enable,
  output logic        MDR_enable,
  output logic        MDR_select,
  output logic        read,
  output logic [15:0] reg_in_sel,
  output logic [15:0] reg_out_sel,
  output logic [4:0]  alu_instruction,
  output logic        done,
  output logic        halted,
  output logic        illegal
);

`ifdef MULDIV_EN
  localparam logic MULDIV_ON = 1'b1;
`else
  localparam logic MULDIV_ON = 1'b0;
`endif

  localparam logic [4:0] OP_LAST_ALU = 5'b01011;
  localparam logic [4:0] OP_MUL      = 5'b01111;
  localparam logic [4:0] OP_DIV      = 5'b10000;
  localparam logic [4:0] OP_HALT     = 5'b11111;

  typedef enum logic [3:0] {
    IDLE = 4'd0, T0 = 4'd1, T1 = 4'd2, T1W = 4'd3, T2 = 4'd4,
    T3   = 4'd5, T4 = 4'd6, T5 = 4'd7, T6  = 4'd8, HALT = 4'd9
  } state_t;

  function automatic logic is_muldiv(input logic [4:0] op);
    return MULDIV_ON && ((op == OP_MUL) || (op == OP_DIV));
  endfunction

  function automatic logic is_legal(input logic [4:0] op);
    return (op <= OP_LAST_ALU) || is_muldiv(op);
  endfunction

  state_t      state_r, state_s;
  logic [4:0]  op_r, op_s;
  logic [3:0]  ra_r, ra_s, rb_r, rb_s, rc_r, rc_s;
  logic        illegal_r, illegal_s;
  logic [11:0] en_s;
  logic [15:0] rin_s, rout_s;
  logic [4:0]  alu_s;
  logic        done_s, halted_s, illegal_out_s;
  logic        unused_ir_s;

  assign unused_ir_s = ^IR_Data[14:0];

  // Next-state and instruction-field latch logic
  always_comb begin
    state_s   = state_r;
    op_s      = op_r;
    ra_s      = ra_r;
    rb_s      = rb_r;
    rc_s      = rc_r;
    illegal_s = illegal_r;
    case (state_r)
      IDLE: if (run) state_s = T0; else state_s = IDLE;
      T0:   state_s = T1;
      T1:   if (mem_ready) state_s = T2; else state_s = T1W;
      T1W:  if (mem_ready) state_s = T2; else state_s = T1W;
      T2: begin
        if (is_legal(IR_Data[31:27])) begin
          state_s = T3;
          op_s    = IR_Data[31:27];
          ra_s    = IR_Data[26:23];
          rb_s    = IR_Data[22:19];
          rc_s    = IR_Data[18:15];
        end else if (IR_Data[31:27] == OP_HALT) begin
          state_s = HALT;
        end else begin
          state_s   = HALT;
          illegal_s = 1'b1;
        end
      end
      T3:   state_s = T4;
      T4:   state_s = T5;
      T5: begin
        if (is_muldiv(op_r)) state_s = T6;
        else if (run)        state_s = T0;
        else                 state_s = IDLE;
      end
      T6:   if (run) state_s = T0; else state_s = IDLE;
      HALT: state_s = HALT;
      default: state_s = IDLE;
    endcase
  end

  // Output decode from the upcoming state so the output flops track the state register.
  // en_s order: PC_select, PC_enable, PC_increment_enable, IR_enable, Y_enable, Z_enable,
  //             Z_LO_select, Z_HI_select, MAR_enable, MDR_enable, MDR_select, read
  always_comb begin
    en_s          = 12'h000;
    rin_s         = 16'h0000;
    rout_s        = 16'h0000;
    alu_s         = 5'd0;
    done_s        = 1'b0;
    halted_s      = 1'b0;
    illegal_out_s = 1'b0;
    case (state_s)
      T0:  en_s = 12'hA48;
      T1:  en_s = 12'h425;
      T1W: en_s = 12'h005;
      T2:  en_s = 12'h102;
      T3: begin
        en_s   = 12'h080;
        rout_s = 16'd1 << rb_s;
      end
      T4: begin
        en_s   = 12'h040;
        rout_s = 16'd1 << rc_s;
        alu_s  = op_s;
      end
      T5: begin
        en_s   = 12'h020;
        rin_s  = 16'd1 << ra_s;
        done_s = !is_muldiv(op_s);
      end
      T6: begin
        en_s   = 12'h010;
        rin_s  = 16'd1 << (ra_s + 4'd1);
        done_s = 1'b1;
      end
      HALT: begin
        halted_s      = 1'b1;
        illegal_out_s = illegal_s;
      end
      default: en_s = 12'h000;
    endcase
  end

  // State, latched fields and registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r         <= IDLE;
      op_r            <= 5'd0;
      ra_r            <= 4'd0;
      rb_r            <= 4'd0;
      rc_r            <= 4'd0;
      illegal_r       <= 1'b0;
      {PC_select, PC_enable, PC_increment_enable, IR_enable, Y_enable, Z_enable,
       Z_LO_select, Z_HI_select, MAR_enable, MDR_enable, MDR_select, read} <= 12'h000;
      reg_in_sel      <= 16'h0000;
      reg_out_sel     <= 16'h0000;
      alu_instruction <= 5'd0;
      done            <= 1'b0;
      halted          <= 1'b0;
      illegal         <= 1'b0;
    end else begin
      state_r         <= state_s;
      op_r            <= op_s;
      ra_r            <= ra_s;
      rb_r            <= rb_s;
      rc_r            <= rc_s;
      illegal_r       <= illegal_s;
      {PC_select, PC_enable, PC_increment_enable, IR_enable, Y_enable, Z_enable,
       Z_LO_select, Z_HI_select, MAR_enable, MDR_enable, MDR_select, read} <= en_s;
      reg_in_sel      <= rin_s;
      reg_out_sel     <= rout_s;
      alu_instruction <= alu_s;
      done            <= done_s;
      halted          <= halted_s;
      illegal         <= illegal_out_s;
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer (default build, MULDIV_EN undefined): directed table,
// hand-written multi-cycle corner sequences, and a randomized instruction stream against a step model.
module tb_alu_sequencer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        run = 1'b0;
  logic        mem_ready = 1'b0;
  logic [31:0] IR_Data = 32'h0;
  logic PC_select, PC_enable, PC_increment_enable, IR_enable, Y_enable, Z_enable;
  logic Z_LO_select, Z_HI_select, MAR_enable, MDR_enable, MDR_select, read;
  logic [15:0] reg_in_sel, reg_out_sel;
  logic [4:0]  alu_instruction;
  logic        done, halted, illegal;

  alu_sequencer dut (
    .clk(clk), .reset_n(reset_n), .run(run), .mem_ready(mem_ready), .IR_Data(IR_Data),
    .PC_select(PC_select), .PC_enable(PC_enable), .PC_increment_enable(PC_increment_enable),
    .IR_enable(IR_enable), .Y_enable(Y_enable), .Z_enable(Z_enable),
    .Z_LO_select(Z_LO_select), .Z_HI_select(Z_HI_select), .MAR_enable(MAR_enable),
    .MDR_enable(MDR_enable), .MDR_select(MDR_select), .read(read),
    .reg_in_sel(reg_in_sel), .reg_out_sel(reg_out_sel), .alu_instruction(alu_instruction),
    .done(done), .halted(halted), .illegal(illegal)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [11:0] en;
    logic [15:0] rin;
    logic [15:0] rout;
    logic [4:0]  alu;
    logic        done;
    logic        halted;
    logic        illegal;
  } out_t;

  localparam logic [11:0] E_PC_SEL = 12'h800, E_PC_EN = 12'h400, E_PC_INC = 12'h200,
                          E_IR_EN  = 12'h100, E_Y_EN  = 12'h080, E_Z_EN   = 12'h040,
                          E_ZLO    = 12'h020, E_ZHI   = 12'h010, E_MAR    = 12'h008,
                          E_MDR_EN = 12'h004, E_MDR_S = 12'h002, E_READ   = 12'h001;

  typedef enum {P_IDLE, P_T0, P_T1, P_T1W, P_T2, P_T3, P_T4, P_T5} ph_t;

  out_t act;
  assign act = {PC_select, PC_enable, PC_increment_enable, IR_enable, Y_enable, Z_enable,
                Z_LO_select, Z_HI_select, MAR_enable, MDR_enable, MDR_select, read,
                reg_in_sel, reg_out_sel, alu_instruction, done, halted, illegal};

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, want, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Spec step table: what each step of the instruction cycle drives
  function automatic out_t exp_of(input ph_t p, input logic [4:0] op,
                                  input logic [3:0] ra, input logic [3:0] rb, input logic [3:0] rc);
    out_t e;
    e = '0;
    case (p)
      P_T0:  e.en = E_PC_SEL | E_MAR | E_PC_INC | E_Z_EN;
      P_T1:  e.en = E_ZLO | E_PC_EN | E_READ | E_MDR_EN;
      P_T1W: e.en = E_READ | E_MDR_EN;
      P_T2:  e.en = E_MDR_S | E_IR_EN;
      P_T3:  begin e.en = E_Y_EN; e.rout = 16'd1 << rb; end
      P_T4:  begin e.en = E_Z_EN; e.rout = 16'd1 << rc; e.alu = op; end
      P_T5:  begin e.en = E_ZLO; e.rin = 16'd1 << ra; e.done = 1'b1; end
      default: e = '0;
    endcase
    return e;
  endfunction

  task automatic do_reset;
    reset_n = 1'b0;
    run = 1'b0;
    mem_ready = 1'b0;
    IR_Data = 32'h0;
    #3;
    chk("in_reset", act, 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
  endtask

  // Run one legal instruction from IDLE (run raised here) or from the final step with run=1.
  task automatic run_instr(input logic [31:0] ir, input int w, input logic run_final,
                           input logic drop_run, output int cyc);
    logic [31:0] irv;
    logic [4:0] op;
    logic [3:0] ra, rb, rc;
    irv = ir;
    op = irv[31:27]; ra = irv[26:23]; rb = irv[22:19]; rc = irv[18:15];
    cyc = 0;
    IR_Data = ir;
    run = 1'b1;
    tick; cyc++; chk("step_t0", act, exp_of(P_T0, op, ra, rb, rc));
    mem_ready = (w == 0);
    tick; cyc++; chk("step_t1", act, exp_of(P_T1, op, ra, rb, rc));
    for (int k = 0; k < w; k++) begin
      tick; cyc++; chk("step_t1w", act, exp_of(P_T1W, op, ra, rb, rc));
      mem_ready = (k == w - 1);
    end
    tick; cyc++; chk("step_t2", act, exp_of(P_T2, op, ra, rb, rc));
    tick; cyc++; chk("step_t3", act, exp_of(P_T3, op, ra, rb, rc));
    IR_Data = $urandom;
    if (drop_run) run = 1'b0;
    tick; cyc++; chk("step_t4", act, exp_of(P_T4, op, ra, rb, rc));
    tick; cyc++; chk("step_t5", act, exp_of(P_T5, op, ra, rb, rc));
    run = run_final;
    if (!run_final) begin
      tick; chk("step_idle", act, 64'd0);
      run = 1'b1;
    end
  endtask

  typedef struct {
    logic [31:0] ir;
    logic        halt;
    logic        ill;
    logic [15:0] rout3;
    logic [15:0] rout4;
    logic [15:0] rin5;
    logic [4:0]  alu;
  } vec_t;

  vec_t tbl[7];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    out_t e;
    logic [31:0] r;

    tbl[0] = '{32'h409A8000, 1'b0, 1'b0, 16'h0008, 16'h0020, 16'h0002, 5'b01000};
    tbl[1] = '{{5'd0, 4'd15, 4'd0, 4'd14, 15'd0}, 1'b0, 1'b0, 16'h0001, 16'h4000, 16'h8000, 5'd0};
    tbl[2] = '{32'h58000000, 1'b0, 1'b0, 16'h0001, 16'h0001, 16'h0001, 5'b01011};
    tbl[3] = '{32'hF8000000, 1'b1, 1'b0, 16'h0, 16'h0, 16'h0, 5'd0};
    tbl[4] = '{32'h78000000, 1'b1, 1'b1, 16'h0, 16'h0, 16'h0, 5'd0};
    tbl[5] = '{32'h60000000, 1'b1, 1'b1, 16'h0, 16'h0, 16'h0, 5'd0};
    tbl[6] = '{32'h80000000, 1'b1, 1'b1, 16'h0, 16'h0, 16'h0, 5'd0};

    for (int i = 0; i < 7; i++) begin
      do_reset();
      chk("reset_state", act, 64'd0);
      IR_Data = tbl[i].ir;
      mem_ready = 1'b1;
      run = 1'b1;
      tick; chk("tbl_t0_pcsel", PC_select, 1'b1);
      tick; chk("tbl_t1_read", read, 1'b1);
      tick; chk("tbl_t2_iren", IR_enable, 1'b1);
      tick;
      if (tbl[i].halt) begin
        e = '0; e.halted = 1'b1; e.illegal = tbl[i].ill;
        chk("tbl_halt", act, e);
        for (int k = 0; k < 3; k++) begin
          run = k[0];
          tick; chk("tbl_halt_hold", act, e);
        end
      end else begin
        chk("tbl_t3_rout", reg_out_sel, tbl[i].rout3);
        tick;
        chk("tbl_t4_rout", reg_out_sel, tbl[i].rout4);
        chk("tbl_t4_alu", alu_instruction, tbl[i].alu);
        tick;
        chk("tbl_t5_rin", reg_in_sel, tbl[i].rin5);
        chk("tbl_t5_done", done, 1'b1);
        chk("tbl_t5_alu0", alu_instruction, 5'd0);
      end
    end

    // Memory wait: three T1W cycles, done on the ninth cycle
    do_reset();
    run_instr(32'h409A8000, 3, 1'b1, 1'b0, cyc);
    chk("wait3_cycles", cyc, 9);
    run_instr(32'h409A8000, 0, 1'b0, 1'b0, cyc);
    chk("nowait_cycles", cyc, 6);

    // run dropped during T3 must not abort; instruction finishes then IDLE
    run_instr(32'h409A8000, 1, 1'b0, 1'b1, cyc);
    chk("droprun_cycles", cyc, 7);

    // Reset pulse mid-T4 clears outputs without a clock edge, then waits for run
    IR_Data = 32'h409A8000;
    mem_ready = 1'b1;
    run = 1'b1;
    for (int k = 0; k < 5; k++) tick;
    chk("pre_reset_t4", act, exp_of(P_T4, 5'b01000, 4'd1, 4'd3, 4'd5));
    #1;
    reset_n = 1'b0;
    #1;
    chk("async_reset_zero", act, 64'd0);
    run = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    tick; chk("idle_no_run", act, 64'd0);
    tick; chk("idle_no_run2", act, 64'd0);
    run_instr(32'h409A8000, 0, 1'b1, 1'b0, cyc);

    // Randomized legal instruction stream against the step model
    for (int n = 0; n < 60; n++) begin
      r = $urandom;
      r[31:27] = 5'($urandom_range(0, 11));
      run_instr(r, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), cyc);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
